// File: rtl/meas_frame_packer_pkg.sv
// Shared types and constants for the measurement frame packer.
package meas_frame_packer_pkg;

    // Serializer state: idle or walking through the bytes of a frame
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int FRAME_LEN = 12;
    localparam int CHK_IDX   = 11;
    localparam int IDX_W     = $clog2(FRAME_LEN);

    localparam logic [7:0] DEF_HDR0 = 8'hA5;
    localparam logic [7:0] DEF_HDR1 = 8'h5A;

    // One captured measurement together with its precomputed checksum
    typedef struct packed {
        logic [31:0] fs;
        logic [31:0] fx;
        logic [7:0]  duty;
        logic [7:0]  chk;
    } sample_t;

    // Modulo-256 sum of the nine payload bytes (headers excluded)
    function automatic logic [7:0] calc_chk(input logic [31:0] fs,
                                            input logic [31:0] fx,
                                            input logic [7:0]  duty);
        logic [7:0] s;
        s = duty;
        for (int i = 0; i < 4; i++) begin
            s = s + fs[8*i +: 8] + fx[8*i +: 8];
        end
        return s;
    endfunction

endpackage

// File: rtl/meas_frame_packer_if.sv
// Sample input and byte-stream output bundle of the frame packer.
// master = packer side, slave = producer/transmitter side.
interface meas_frame_packer_if;
    logic        meas_valid;
    logic [31:0] fs_cnt;
    logic [31:0] fx_cnt;
    logic [7:0]  duty;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;
    logic [7:0]  overrun_cnt;

    modport master (
        input  meas_valid, fs_cnt, fx_cnt, duty, tx_ready,
        output tx_data, tx_valid, busy, frame_done, overrun_cnt
    );

    modport slave (
        output meas_valid, fs_cnt, fx_cnt, duty, tx_ready,
        input  tx_data, tx_valid, busy, frame_done, overrun_cnt
    );
endinterface

// File: rtl/meas_frame_buf.sv
// Active/pending sample storage with overwrite tracking. The active
// register only changes between frames, so the serializer can read it
// directly while a frame is in flight.
module meas_frame_buf
    import meas_frame_packer_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        meas_valid,
    input  logic [31:0] fs_cnt,
    input  logic [31:0] fx_cnt,
    input  logic [7:0]  duty,
    input  logic        in_send,      // serializer is walking a frame
    input  logic        frame_end,    // last byte transfers this cycle
    output sample_t     active,
    output logic        pending_full,
    output logic [7:0]  overrun_cnt,
    output logic        start_frame   // a fresh frame begins next cycle
);

    sample_t    active_q, active_d;
    sample_t    pend_q, pend_d;
    logic       pend_full_q, pend_full_d;
    logic [7:0] overrun_q, overrun_d;
    sample_t    new_s;
    logic [7:0] overrun_inc;

    // Incoming sample with its checksum formed at capture time
    always_comb begin
        new_s.fs   = fs_cnt;
        new_s.fx   = fx_cnt;
        new_s.duty = duty;
        new_s.chk  = calc_chk(fs_cnt, fx_cnt, duty);
    end

    assign overrun_inc = (overrun_q == 8'hFF) ? overrun_q : overrun_q + 8'd1;

    // Route samples to active/pending and count overwrites of a full pending slot
    always_comb begin
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        overrun_d   = overrun_q;
        if (!in_send) begin
            if (meas_valid) begin
                active_d = new_s;
            end
        end else if (frame_end) begin
            if (pend_full_q) begin
                active_d = pend_q;
                if (meas_valid) begin
                    pend_d      = new_s;
                    pend_full_d = 1'b1;
                    overrun_d   = overrun_inc;
                end else begin
                    pend_full_d = 1'b0;
                end
            end else if (meas_valid) begin
                active_d = new_s;
            end
        end else if (meas_valid) begin
            pend_d      = new_s;
            pend_full_d = 1'b1;
            if (pend_full_q) begin
                overrun_d = overrun_inc;
            end
        end
    end

    // Storage registers, cleared by the asynchronous reset
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            active_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            overrun_q   <= 8'h00;
        end else begin
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            overrun_q   <= overrun_d;
        end
    end

    assign active       = active_q;
    assign pending_full = pend_full_q;
    assign overrun_cnt  = overrun_q;
    assign start_frame  = (!in_send && meas_valid) ||
                          (frame_end && (pend_full_q || meas_valid));

endmodule

// File: rtl/meas_frame_packer.sv
// Packs each measurement sample into a 12-byte frame and streams it
// out over a valid/ready byte interface toward a UART transmitter.
module meas_frame_packer
    import meas_frame_packer_pkg::*;
#(
    parameter logic [7:0] HDR0 = DEF_HDR0,
    parameter logic [7:0] HDR1 = DEF_HDR1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    meas_frame_packer_if.master    bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHK_IDX);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;

    sample_t          active;
    logic             pending_full;
    logic             start_frame;
    logic             xfer;
    logic             last_xfer;

    assign xfer      = tx_valid_q && bus.tx_ready;
    assign last_xfer = xfer && (idx_q == LAST_IDX);

    meas_frame_buf u_buf (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .meas_valid   (bus.meas_valid),
        .fs_cnt       (bus.fs_cnt),
        .fx_cnt       (bus.fx_cnt),
        .duty         (bus.duty),
        .in_send      (state_q == ST_SEND),
        .frame_end    (last_xfer),
        .active       (active),
        .pending_full (pending_full),
        .overrun_cnt  (bus.overrun_cnt),
        .start_frame  (start_frame)
    );

    // Byte at a given frame position; counts go out most-significant first
    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                              input sample_t s);
        logic [7:0] b;
        case (idx)
            4'd0:    b = HDR0;
            4'd1:    b = HDR1;
            4'd2:    b = s.fs[31:24];
            4'd3:    b = s.fs[23:16];
            4'd4:    b = s.fs[15:8];
            4'd5:    b = s.fs[7:0];
            4'd6:    b = s.fx[31:24];
            4'd7:    b = s.fx[23:16];
            4'd8:    b = s.fx[15:8];
            4'd9:    b = s.fx[7:0];
            4'd10:   b = s.duty;
            4'd11:   b = s.chk;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Next-state and next-output logic of the serializer
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start_frame) begin
                    state_d    = ST_SEND;
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = HDR0;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (start_frame) begin
                            tx_data_d = HDR0;
                        end else begin
                            state_d    = ST_IDLE;
                            tx_valid_d = 1'b0;
                            tx_data_d  = 8'h00;
                        end
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        tx_data_d = frame_byte(idx_q + 1'b1, active);
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                idx_d      = '0;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase
    end

    // Serializer state and registered stream outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.frame_done = last_xfer;
    assign bus.busy       = (state_q == ST_SEND) || pending_full;

endmodule

// File: tb/tb_meas_frame_packer.sv
// Self-checking bench for meas_frame_packer: directed scenarios plus a
// randomized run, all checked against a frame-level reference model.
module tb_meas_frame_packer;

    typedef logic [11:0][7:0] frame_t;

    logic clk;
    logic rst_n;
    meas_frame_packer_if bus_if();

    meas_frame_packer #(.HDR0(8'hA5), .HDR1(8'h5A)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] got_bytes[$];
    int         got_cyc[$];
    int         done_cyc[$];

    localparam logic [7:0] EXP1 [12] = '{8'hA5, 8'h5A, 8'h02, 8'hFA, 8'hF0, 8'h80,
                                         8'h00, 8'h00, 8'h03, 8'hE8, 8'h32, 8'h89};
    localparam logic [7:0] EXP2 [12] = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h01,
                                         8'h00, 8'h00, 8'h00, 8'h02, 8'h03, 8'h06};

    // Frame contents straight from the frame layout: headers, big-endian
    // counts, duty, then the byte sum of positions 2..10
    function automatic frame_t build_frame(input logic [31:0] fs,
                                           input logic [31:0] fx,
                                           input logic [7:0]  d);
        frame_t f;
        int     sum;
        f[0] = 8'hA5;
        f[1] = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            f[2+i] = fs[31-8*i -: 8];
            f[6+i] = fx[31-8*i -: 8];
        end
        f[10] = d;
        sum = 0;
        for (int i = 2; i <= 10; i++) sum += int'(f[i]);
        f[11] = 8'(sum % 256);
        return f;
    endfunction

    // Reference model: the frame in flight, the position within it, the one
    // waiting sample, and the count of samples that were overwritten
    bit     m_busy, m_pend;
    int     m_pos, m_ovr;
    frame_t m_frame, m_pend_frame;

    always @(posedge clk) cyc = cyc + 1;

    // Per-cycle scoreboard against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            n_checks++;
            if (bus_if.tx_valid !== 1'b0 || bus_if.tx_data !== 8'h00 || bus_if.busy !== 1'b0 ||
                bus_if.frame_done !== 1'b0 || bus_if.overrun_cnt !== 8'h00) begin
                n_fail++;
                $display("FAIL mon_reset cyc=%0d got v=%b d=%h busy=%b done=%b ovr=%h exp all zero",
                         cyc, bus_if.tx_valid, bus_if.tx_data, bus_if.busy, bus_if.frame_done,
                         bus_if.overrun_cnt);
            end
            m_busy = 0; m_pend = 0; m_pos = 0; m_ovr = 0;
        end else begin
            frame_t nf;
            bit     done_exp;
            nf = build_frame(bus_if.fs_cnt, bus_if.fx_cnt, bus_if.duty);
            done_exp = m_busy && bus_if.tx_ready && (m_pos == 11);
            n_checks++;
            if (bus_if.tx_valid !== m_busy || (m_busy && bus_if.tx_data !== m_frame[m_pos])) begin
                n_fail++;
                $display("FAIL mon_stream cyc=%0d got v=%b d=%h exp v=%b d=%h",
                         cyc, bus_if.tx_valid, bus_if.tx_data, m_busy, m_busy ? m_frame[m_pos] : 8'h00);
            end
            n_checks++;
            if (bus_if.busy !== (m_busy | m_pend) || bus_if.frame_done !== done_exp ||
                bus_if.overrun_cnt !== 8'(m_ovr)) begin
                n_fail++;
                $display("FAIL mon_status cyc=%0d got busy=%b done=%b ovr=%0d exp busy=%b done=%b ovr=%0d",
                         cyc, bus_if.busy, bus_if.frame_done, bus_if.overrun_cnt,
                         m_busy | m_pend, done_exp, m_ovr);
            end
            if (bus_if.tx_valid && bus_if.tx_ready) begin
                got_bytes.push_back(bus_if.tx_data);
                got_cyc.push_back(cyc);
            end
            if (bus_if.frame_done) begin
                done_cyc.push_back(cyc);
                $display("frame sent at cycle %0d, overruns %0d", cyc, bus_if.overrun_cnt);
            end
            // Advance the model across the coming edge
            if (!m_busy) begin
                if (bus_if.meas_valid) begin
                    m_frame = nf; m_busy = 1; m_pos = 0;
                end
            end else if (done_exp) begin
                m_pos = 0;
                if (m_pend) begin
                    m_frame = m_pend_frame;
                    if (bus_if.meas_valid) begin
                        m_pend_frame = nf;
                        m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
                    end else begin
                        m_pend = 0;
                    end
                end else if (bus_if.meas_valid) begin
                    m_frame = nf;
                end else begin
                    m_busy = 0;
                end
            end else begin
                if (bus_if.tx_ready) m_pos++;
                if (bus_if.meas_valid) begin
                    if (m_pend) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
                    m_pend_frame = nf;
                    m_pend = 1;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        got_bytes.delete();
        got_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus_if.meas_valid = 1'b0;
        bus_if.tx_ready = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(1);
        clear_log();
    endtask

    task automatic strobe(input logic [31:0] fs, input logic [31:0] fx, input logic [7:0] d);
        bus_if.meas_valid = 1'b1;
        bus_if.fs_cnt = fs;
        bus_if.fx_cnt = fx;
        bus_if.duty = d;
        wait_cyc(1);
        bus_if.meas_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        bus_if.meas_valid = 1'b0;
        bus_if.tx_ready = 1'b1;
        while (bus_if.busy !== 1'b0 && n < 400) begin
            wait_cyc(1);
            n++;
        end
        if (n >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain_timeout busy=%b after %0d cycles, required 0", name, bus_if.busy, n);
        end
        wait_cyc(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.meas_valid = 1'b0;
        bus_if.tx_ready = 1'b1;
        bus_if.fs_cnt = '0;
        bus_if.fx_cnt = '0;
        bus_if.duty = '0;
        wait_cyc(3);
        n_checks++;
        if (bus_if.tx_valid !== 1'b0 || bus_if.tx_data !== 8'h00 || bus_if.busy !== 1'b0 ||
            bus_if.overrun_cnt !== 8'h00 || bus_if.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b d=%h busy=%b ovr=%h done=%b required all zero",
                     bus_if.tx_valid, bus_if.tx_data, bus_if.busy, bus_if.overrun_cnt, bus_if.frame_done);
        end
        rst_n = 1'b1;
        wait_cyc(2);
        n_checks++;
        if (bus_if.tx_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got v=%b busy=%b required 0 0", bus_if.tx_valid, bus_if.busy);
        end
    endtask

    task automatic test_single_frame();
        int s;
        apply_reset();
        bus_if.tx_ready = 1'b1;
        s = cyc;
        strobe(32'h02FAF080, 32'h000003E8, 8'h32);
        drain("single");
        n_checks++;
        if (got_bytes.size() != 12 || done_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL single_count got %0d bytes %0d done required 12 1", got_bytes.size(), done_cyc.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (got_bytes[i] !== EXP1[i] || got_cyc[i] != s + 1 + i) begin
                    n_fail++;
                    $display("FAIL single_byte%0d got %h at cyc %0d required %h at cyc %0d",
                             i, got_bytes[i], got_cyc[i], EXP1[i], s + 1 + i);
                end
            end
            n_checks++;
            if (done_cyc[0] != s + 12) begin
                n_fail++;
                $display("FAIL single_done got cyc %0d required %0d", done_cyc[0], s + 12);
            end
        end
    endtask

    task automatic test_backpressure();
        bit pat [4];
        int k;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset();
        strobe(32'h02FAF080, 32'h000003E8, 8'h32);
        k = 0;
        while (got_bytes.size() < 12 && k < 300) begin
            n_checks++;
            if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== EXP1[got_bytes.size()]) begin
                n_fail++;
                $display("FAIL bp_hold step %0d got v=%b d=%h required 1 %h",
                         k, bus_if.tx_valid, bus_if.tx_data, EXP1[got_bytes.size()]);
            end
            bus_if.tx_ready = (k < 4) ? pat[k] : 1'($urandom_range(0, 1));
            wait_cyc(1);
            k++;
        end
        drain("bp");
        n_checks++;
        if (got_bytes.size() != 12) begin
            n_fail++;
            $display("FAIL bp_count got %0d bytes required 12", got_bytes.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (got_bytes[i] !== EXP1[i]) begin
                    n_fail++;
                    $display("FAIL bp_byte%0d got %h required %h", i, got_bytes[i], EXP1[i]);
                end
            end
        end
    endtask

    task automatic test_pending();
        int s;
        apply_reset();
        bus_if.tx_ready = 1'b1;
        s = cyc;
        strobe(32'h02FAF080, 32'h000003E8, 8'h32);
        wait_cyc(s + 5 - cyc);
        strobe(32'd1, 32'd2, 8'd3);
        drain("pend");
        n_checks++;
        if (got_bytes.size() != 24) begin
            n_fail++;
            $display("FAIL pend_count got %0d bytes required 24", got_bytes.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (got_bytes[i] !== EXP1[i] || got_bytes[12+i] !== EXP2[i]) begin
                    n_fail++;
                    $display("FAIL pend_byte%0d got %h/%h required %h/%h",
                             i, got_bytes[i], got_bytes[12+i], EXP1[i], EXP2[i]);
                end
            end
            n_checks++;
            if (got_cyc[12] != s + 13) begin
                n_fail++;
                $display("FAIL pend_gap got frame2 at cyc %0d required %0d", got_cyc[12], s + 13);
            end
        end
        n_checks++;
        if (bus_if.overrun_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL pend_ovr got %0d required 0", bus_if.overrun_cnt);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] fs, fx;
        logic [7:0]  d;
        frame_t      ef;
        apply_reset();
        bus_if.tx_ready = 1'b1;
        strobe($urandom, $urandom, 8'($urandom));
        wait_cyc(2);
        strobe($urandom, $urandom, 8'($urandom));
        wait_cyc(2);
        fs = $urandom; fx = $urandom; d = 8'($urandom);
        strobe(fs, fx, d);
        ef = build_frame(fs, fx, d);
        drain("ovr");
        n_checks++;
        if (got_bytes.size() != 24) begin
            n_fail++;
            $display("FAIL ovr_count got %0d bytes required 24", got_bytes.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (got_bytes[12+i] !== ef[i]) begin
                    n_fail++;
                    $display("FAIL ovr_byte%0d got %h required %h", i, got_bytes[12+i], ef[i]);
                end
            end
        end
        n_checks++;
        if (bus_if.overrun_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL ovr_cnt got %0d required 1", bus_if.overrun_cnt);
        end

        // Saturation: stall the transmitter and strobe every cycle
        apply_reset();
        bus_if.tx_ready = 1'b0;
        bus_if.meas_valid = 1'b1;
        for (int i = 1; i <= 302; i++) begin
            fs = $urandom; fx = $urandom; d = 8'($urandom);
            bus_if.fs_cnt = fs; bus_if.fx_cnt = fx; bus_if.duty = d;
            wait_cyc(1);
            if (i == 100 || i == 256 || i == 257) begin
                n_checks++;
                if (bus_if.overrun_cnt !== 8'(i - 2)) begin
                    n_fail++;
                    $display("FAIL sat_cnt_at_%0d got %0d required %0d", i, bus_if.overrun_cnt, i - 2);
                end
            end
        end
        bus_if.meas_valid = 1'b0;
        ef = build_frame(fs, fx, d);
        n_checks++;
        if (bus_if.overrun_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL sat_cnt got %h required ff", bus_if.overrun_cnt);
        end
        drain("sat");
        n_checks++;
        if (got_bytes.size() != 24 || got_bytes[23] !== ef[11] || got_bytes[15] !== ef[3]) begin
            n_fail++;
            $display("FAIL sat_last_frame got %0d bytes chk %h required 24 bytes chk %h",
                     got_bytes.size(), got_bytes.size() == 24 ? got_bytes[23] : 8'h00, ef[11]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] fs, fx;
        logic [7:0]  d;
        frame_t      ef;
        int          s;
        apply_reset();
        bus_if.tx_ready = 1'b1;
        s = cyc;
        strobe(32'h02FAF080, 32'h000003E8, 8'h32);
        wait_cyc(s + 7 - cyc);
        n_checks++;
        if (bus_if.tx_data !== EXP1[6]) begin
            n_fail++;
            $display("FAIL rstmid_pos got %h required %h", bus_if.tx_data, EXP1[6]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_if.tx_valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_now got v=%b busy=%b d=%h required 0 0 00",
                     bus_if.tx_valid, bus_if.busy, bus_if.tx_data);
        end
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(1);
        clear_log();
        fs = $urandom; fx = $urandom; d = 8'($urandom);
        ef = build_frame(fs, fx, d);
        strobe(fs, fx, d);
        drain("rstmid");
        n_checks++;
        if (got_bytes.size() != 12) begin
            n_fail++;
            $display("FAIL rstmid_count got %0d bytes required 12", got_bytes.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (got_bytes[i] !== ef[i]) begin
                    n_fail++;
                    $display("FAIL rstmid_byte%0d got %h required %h", i, got_bytes[i], ef[i]);
                end
            end
        end
    endtask

    task automatic test_boundary();
        int s;
        apply_reset();
        bus_if.tx_ready = 1'b1;
        s = cyc;
        strobe(32'h02FAF080, 32'h000003E8, 8'h32);
        wait_cyc(s + 12 - cyc);
        strobe(32'd1, 32'd2, 8'd3);
        drain("bound");
        n_checks++;
        if (got_bytes.size() != 24 || done_cyc.size() != 2) begin
            n_fail++;
            $display("FAIL bound_count got %0d bytes %0d done required 24 2", got_bytes.size(), done_cyc.size());
        end else begin
            n_checks++;
            if (got_cyc[12] != s + 13 || done_cyc[1] != s + 24) begin
                n_fail++;
                $display("FAIL bound_timing got start %0d done %0d required %0d %0d",
                         got_cyc[12], done_cyc[1], s + 13, s + 24);
            end
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (got_bytes[12+i] !== EXP2[i]) begin
                    n_fail++;
                    $display("FAIL bound_byte%0d got %h required %h", i, got_bytes[12+i], EXP2[i]);
                end
            end
        end
        n_checks++;
        if (bus_if.overrun_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL bound_ovr got %0d required 0", bus_if.overrun_cnt);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 1500; k++) begin
            bus_if.meas_valid = ($urandom_range(0, 11) == 0);
            bus_if.fs_cnt = $urandom;
            bus_if.fx_cnt = $urandom;
            bus_if.duty = 8'($urandom);
            bus_if.tx_ready = ($urandom_range(0, 3) != 0);
            wait_cyc(1);
        end
        drain("rand");
        n_checks++;
        if (got_bytes.size() % 12 != 0 || bus_if.tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_whole_frames got %0d bytes v=%b required multiple of 12, v=0",
                     got_bytes.size(), bus_if.tx_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus_if.meas_valid = 1'b0;
        bus_if.tx_ready = 1'b0;
        bus_if.fs_cnt = '0;
        bus_if.fx_cnt = '0;
        bus_if.duty = '0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_pending();
        test_overrun();
        test_reset_mid();
        test_boundary();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/meas_frame_packer.md
MEAS_FRAME_PACKER -- requirements
Module: meas_frame_packer

Interface
REQ-001 Parameter HDR0, default 8'hA5, first frame sync byte.
REQ-002 Parameter HDR1, default 8'h5A, second frame sync byte.
REQ-003 sys_clk  input  1  system clock; all logic on its rising edge.
REQ-004 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 meas_valid  input  1  single-cycle strobe; fs_cnt/fx_cnt/duty valid this cycle.
REQ-006 fs_cnt  input  32  reference-clock count for the gate.
REQ-007 fx_cnt  input  32  measured-clock count for the gate.
REQ-008 duty  input  8  duty-cycle byte.
REQ-009 tx_data  output  8  byte to the UART transmitter.
REQ-010 tx_valid  output  1  tx_data holds a byte.
REQ-011 tx_ready  input  1  transmitter accepts the byte this cycle.
REQ-012 busy  output  1  high while a frame is in flight or a sample is pending.
REQ-013 frame_done  output  1  one-cycle pulse when the last frame byte transfers.
REQ-014 overrun_cnt  output  8  saturating count of samples lost to overwrite.

Function
REQ-015 Frame is 12 bytes: HDR0, HDR1, fs_cnt[31:24..7:0], fx_cnt[31:24..7:0], duty, CHK. Counts are sent big-endian.
REQ-016 CHK is the 8-bit modulo-256 sum of the 9 payload bytes (indices 2..10); headers are excluded.
REQ-017 A byte transfers when tx_valid and tx_ready are both high at a rising edge.
REQ-018 tx_valid and tx_data are registered outputs.
REQ-019 tx_data holds stable while tx_valid=1 and tx_ready=0.
REQ-020 tx_valid never drops before its byte transfers.
REQ-021 FSM has 2 states:
  - IDLE: tx_valid=0.
  - SEND: byte index 0..11, advanced on each transfer.
REQ-022 IDLE + meas_valid captures the inputs into the active frame register; SEND starts with byte 0 and tx_valid=1 on the next cycle (1-cycle latency).
REQ-023 CHK is accumulated at capture time and is not recomputed from the serializer.
REQ-024 meas_valid during SEND:
  - Inputs go to a one-deep pending register.
  - If pending is already full, it is overwritten with the newer sample and overrun_cnt increments, saturating at 8'hFF.
REQ-025 On transfer of byte 11:
  - frame_done pulses.
  - If pending is full, it moves to the active register, pending clears, and byte 0 of the new frame is presented the next cycle with no idle gap.
  - Otherwise the FSM returns to IDLE.
REQ-026 meas_valid in the same cycle as the byte-11 transfer with pending empty: the new sample becomes the next frame directly; overrun_cnt is unchanged.
REQ-027 meas_valid in the same cycle as the byte-11 transfer with pending full: pending is sent next and is overwritten by the new sample; overrun_cnt increments.
REQ-028 The frame in flight is never modified by new samples.
REQ-029 tx_ready while tx_valid=0 is ignored.
REQ-030 busy = (state==SEND) | pending_full.

Reset
REQ-031 Asserting sys_rst_n at any time forces the following immediately, aborting any partial frame:
  - FSM to IDLE, byte index 0.
  - tx_valid=0, tx_data=8'h00.
  - frame_done=0, busy=0.
  - pending cleared, overrun_cnt=0.
REQ-032 After release, the first meas_valid starts a complete frame from HDR0.

Structure
REQ-033 A shared package holds:
  - FSM state typedef.
  - FRAME_LEN=12.
  - CHK_IDX=11.
  - Default header constants.
REQ-034 One sub-module, meas_frame_buf, holds the active and pending registers, the overwrite/overrun logic and checksum accumulation; the top holds the FSM and serializer.

Verification
REQ-035 Single frame: reset, then meas_valid with fs=32'h02FAF080, fx=32'h000003E8, duty=8'h32, tx_ready=1 held. Required:
  - Bytes A5 5A 02 FA F0 80 00 00 03 E8 32 89 on 12 consecutive cycles starting 1 cycle after the strobe.
  - frame_done pulses with the 89 byte.
REQ-036 Backpressure: same sample with tx_ready toggling 1-0-0-1 pseudo-randomly. Required:
  - Identical byte sequence.
  - tx_data/tx_valid never change while stalled.
REQ-037 Pending: second sample (fs=1, fx=2, duty=3) during byte 4 of frame 1. Required:
  - Frame 2 = A5 5A 00 00 00 01 00 00 00 02 03 06, starting the cycle after frame 1 byte 11.
  - overrun_cnt=0.
REQ-038 Overrun: three samples strobed during one frame. Required:
  - Only the third is sent next.
  - overrun_cnt=1.
  - 300 overruns saturate at 8'hFF.
REQ-039 Reset mid-frame: assert sys_rst_n low during byte 6. Required:
  - tx_valid=0 and busy=0 immediately.
  - The next strobe yields a full frame starting with A5.
REQ-040 Boundary: meas_valid coincident with the byte-11 transfer, pending empty. Required:
  - New frame begins the next cycle.
  - overrun_cnt unchanged.
